// File: rtl/sif_arb_pkg.sv
// Shared types and helpers for the sif X-side access arbiter.
package sif_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_WAIT_RD = 2'd2;
    localparam state_t ST_RESP    = 2'd3;

    // Width of an index into n requesters, never less than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sif_xa_arbiter_rr.sv
// Combinational round-robin pick: first set request after 'last', wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic found;
    int   c;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        c           = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_i) + k) % N;
            if (en_i && !found && req_i[c]) begin
                found       = 1'b1;
                grant_o[c]  = 1'b1;
                grant_idx_o = IW'(c);
            end
        end
    end

endmodule

// File: rtl/sif_xa_arbiter.sv
// Shares the sif xa port between N_REQ requesters, one transaction at a time.
module sif_xa_arbiter
    import sif_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ-1:0]  req_wr,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]  rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              xa_wr_s,
    output logic              xa_rd_s,
    output logic [AW-1:0]     xa_addr,
    output logic [DW-1:0]     xa_data_wr,
    input  logic [DW-1:0]     xa_data_rd,
    output logic [1:0]        dbg_state_o
);

    localparam int IW = idx_w(N_REQ);
    localparam int CW = 3;

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic               wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               wr_s_q, wr_s_d;
    logic               rd_s_q, rd_s_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rdata_q, rdata_d;

    logic [N_REQ-1:0]   grant;
    logic [IW-1:0]      gidx;
    logic               hs;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i       (req_valid),
        .last_i      (last_q),
        .en_i        (state_q == ST_IDLE),
        .grant_o     (grant),
        .grant_idx_o (gidx)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_s_d      = 1'b0;
        rd_s_d      = 1'b0;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    // Strobes are registered here so they appear exactly in ISSUE.
                    last_d  = gidx;
                    owner_d = gidx;
                    wr_d    = req_wr[gidx];
                    addr_d  = req_addr[int'(gidx)*AW +: AW];
                    if (req_wr[gidx]) wdata_d = req_wdata[int'(gidx)*DW +: DW];
                    wr_s_d  = req_wr[gidx];
                    rd_s_d  = !req_wr[gidx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RD;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            ST_WAIT_RD: begin
                if (cnt_q == '0) begin
                    rdata_d              = xa_data_rd;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= IW'(N_REQ - 1);
            owner_q     <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_s_q      <= 1'b0;
            rd_s_q      <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_s_q      <= wr_s_d;
            rd_s_q      <= rd_s_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign xa_wr_s     = wr_s_q;
    assign xa_rd_s     = rd_s_q;
    assign xa_addr     = addr_q;
    assign xa_data_wr  = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign dbg_state_o = state_q;

endmodule
